// File: rtl/serial_frame_tx_pkg.sv
// Shared FSM encodings and serial line levels for the serial frame transmitter and its matching receiver.
package serial_frame_tx_pkg;

    typedef enum logic [2:0] {
        SFT_IDLE   = 3'd0,
        SFT_START  = 3'd1,
        SFT_DATA   = 3'd2,
        SFT_PARITY = 3'd3,
        SFT_STOP   = 3'd4
    } sft_state_e;

    localparam logic SF_IDLE_LVL  = 1'b0;
    localparam logic SF_START_LVL = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter: counts 0..BIT_CYC-1 while running and ticks on the last cycle of each bit.
// o_tick_nxt predicts the tick one cycle ahead so callers can register tick-aligned outputs.
module bit_timer #(
    parameter int BIT_CYC = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    output logic o_tick,
    output logic o_tick_nxt
);
    localparam int CNT_W = $clog2(BIT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign o_tick = i_run && (r_cnt == CNT_LAST);

    always_comb begin
        w_cnt_nxt = '0;
        if (i_run && !o_tick) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    assign o_tick_nxt = (w_cnt_nxt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: START(1), DATA_W bits MSB first, optional even PARITY, STOP(0); BIT_CYC cycles per bit.
// Parity bit enabled by SERIAL_FRAME_TX_PARITY_EN; all outputs registered, tx_ready high only in IDLE.
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int BIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              data_out,
    output logic              busy,
    output logic              done
);
    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    sft_state_e        r_state;
    sft_state_e        w_state_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic              w_run;
    logic              w_tick;
    logic              w_tick_nxt;
    logic              w_line_nxt;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic              r_par;
`endif

    assign w_run = (r_state != SFT_IDLE);

    bit_timer #(
        .BIT_CYC    (BIT_CYC)
    ) u_bit_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_run      (w_run),
        .o_tick     (w_tick),
        .o_tick_nxt (w_tick_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        case (r_state)
            SFT_IDLE: begin
                if (tx_valid && tx_ready) begin
                    w_state_nxt = SFT_START;
                    w_shift_nxt = tx_data;
                    w_idx_nxt   = '0;
                end
            end
            SFT_START: begin
                if (w_tick) w_state_nxt = SFT_DATA;
            end
            SFT_DATA: begin
                if (w_tick) begin
                    if (r_idx == IDX_LAST) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        w_state_nxt = SFT_PARITY;
`else
                        w_state_nxt = SFT_STOP;
`endif
                    end else begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
                    end
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            SFT_PARITY: begin
                if (w_tick) w_state_nxt = SFT_STOP;
            end
`endif
            SFT_STOP: begin
                if (w_tick) w_state_nxt = SFT_IDLE;
            end
            default: w_state_nxt = SFT_IDLE;
        endcase
    end

    // The line register is loaded with the level of the state being entered, so it lines up with the state.
    always_comb begin
        w_line_nxt = SF_IDLE_LVL;
        case (w_state_nxt)
            SFT_START:  w_line_nxt = SF_START_LVL;
            SFT_DATA:   w_line_nxt = w_shift_nxt[DATA_W-1];
`ifdef SERIAL_FRAME_TX_PARITY_EN
            SFT_PARITY: w_line_nxt = r_par;
`endif
            default:    w_line_nxt = SF_IDLE_LVL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= SFT_IDLE;
            r_shift  <= '0;
            r_idx    <= '0;
            data_out <= SF_IDLE_LVL;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_idx    <= w_idx_nxt;
            data_out <= w_line_nxt;
            tx_ready <= (w_state_nxt == SFT_IDLE);
            busy     <= (w_state_nxt != SFT_IDLE);
            done     <= (w_state_nxt == SFT_STOP) && w_tick_nxt;
        end
    end

`ifdef SERIAL_FRAME_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (r_state == SFT_IDLE && tx_valid && tx_ready) begin
            r_par <= ^tx_data;
        end
    end
`endif

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: accepted words are queued, a negedge monitor rebuilds each frame and checks it.
module tb_serial_frame_tx;
    localparam int DW = 8;
    localparam int BC = 3;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB = 2 + DW + P;
    localparam int F  = NB * BC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_ready;
    logic          data_out;
    logic          busy;
    logic          done;

    serial_frame_tx #(
        .DATA_W   (DW),
        .BIT_CYC  (BC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_acc = 0;
    int            n_frames = 0;
    int            n_abort = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at time %0t", name, $time);
    endtask

    // Reference frame: list of line levels per bit, each stretched to BC cycles; leftmost = first cycle.
    function automatic logic [F-1:0] model_line(input logic [DW-1:0] w);
        logic [F-1:0] v;
        int           bits[$];
        v = '0;
        bits.push_back(1);
        for (int i = 0; i < DW; i++) bits.push_back(int'(w[DW-1-i]));
        if (P == 1) bits.push_back(int'(^w));
        bits.push_back(0);
        for (int b = 0; b < NB; b++)
            for (int c = 0; c < BC; c++)
                v[F-1-(b*BC+c)] = (bits[b] != 0);
        return v;
    endfunction

    // Monitor
    logic [F-1:0]  got_line;
    logic [F-1:0]  got_done;
    logic [DW-1:0] cur;
    int            pos = 0;
    bit            in_frame = 0;
    bit            post = 0;
    bit            hs_err = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 0;
            post     = 0;
        end else begin
            if (post) begin
                check("idle_gap{rdy,busy,line,done}", {60'd0, tx_ready, busy, data_out, done}, 64'b1000);
                post = 0;
            end
            if (!in_frame && busy) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_frame");
                end else begin
                    cur      = exp_q.pop_front();
                    in_frame = 1;
                    pos      = 0;
                    got_line = '0;
                    got_done = '0;
                    hs_err   = 0;
                end
            end else if (!in_frame && done) begin
                fail_now("stray_done");
            end
            if (in_frame) begin
                got_line[F-1-pos] = data_out;
                got_done[F-1-pos] = done;
                if (!busy || tx_ready) hs_err = 1;
                pos++;
                if (pos == F) begin
                    check($sformatf("frame_line[%0h]", cur), 64'(got_line), 64'(model_line(cur)));
                    check($sformatf("frame_done[%0h]", cur), 64'(got_done), 64'd1);
                    check("frame_busy_ready", 64'(hs_err), 64'd0);
                    n_frames++;
                    in_frame = 0;
                    post     = 1;
                end
            end
        end
    end

    // Driver
    task automatic send(input logic [DW-1:0] w);
        bit ok;
        ok = 0;
        for (int i = 0; i < 4 * F && !ok; i++) begin
            @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = w;
            if (tx_ready) begin
                exp_q.push_back(w);
                n_acc++;
                ok = 1;
            end
        end
        if (!ok) fail_now("send_timeout");
    endtask

    task automatic drive_rand(input int n, input int vld_pct);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tx_valid = ($urandom_range(99) < vld_pct);
            tx_data  = DW'($urandom);
            if (tx_valid && tx_ready) begin
                exp_q.push_back(tx_data);
                n_acc++;
            end
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int i = 0; i < 8 * F && !ok; i++) begin
            @(negedge clk);
            if (!busy && !in_frame && exp_q.size() == 0) ok = 1;
        end
        if (!ok) fail_now("idle_timeout");
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx_ready", 64'(tx_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_line_no_valid", 64'({busy, data_out}), 64'd0);

        send(8'hA5); wait_idle();
        send(8'h07); wait_idle();
        send(8'h80); wait_idle();
        send(8'hFF); send(8'h00); wait_idle();

        // New words presented throughout a frame must not disturb it.
        send(8'h3C);
        drive_rand(2 * F, 100);
        wait_idle();

        // Reset in the middle of the 4th data bit.
        send(8'hFF);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (13) @(negedge clk);
        check("pre_reset_line", 64'({busy, data_out}), 64'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_data_out", 64'(data_out), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_tx_ready", 64'(tx_ready), 64'd1);
        check("abort_done", 64'(done), 64'd0);
        n_abort++;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        send(8'hA5); wait_idle();

        drive_rand(1500, 30);
        drive_rand(600, 100);
        wait_idle();
        repeat (3) @(negedge clk);
        check("frame_count", 64'(n_frames + n_abort), 64'(n_acc));
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
